// File: rtl/wb_sequencer_if.sv
// Handshake and bus signals between the control FSM and the write-back sequencer.
// The master modport is the control-unit side; the slave modport is the sequencer.
interface wb_sequencer_if;
  logic       wb_req;
  logic [3:0] wb_kind;
  logic [4:0] rd;
  logic [4:0] rt;
  logic       md_busy;
  logic [2:0] wd_sel;
  logic [4:0] wr_reg;
  logic       reg_write;
  logic       busy;
  logic       wb_done;
  logic       wb_err;

  modport master (
    output wb_req, wb_kind, rd, rt, md_busy,
    input  wd_sel, wr_reg, reg_write, busy, wb_done, wb_err
  );

  modport slave (
    input  wb_req, wb_kind, rd, rt, md_busy,
    output wd_sel, wr_reg, reg_write, busy, wb_done, wb_err
  );
endinterface

// File: rtl/wb_sequencer.sv
// Multicycle write-back controller: waits out the data-source latency or the
// mult/div busy handshake, then issues a one-cycle register-bank write.
module wb_sequencer #(
  parameter int MEM_LAT    = 2,
  parameter int SHIFT_LAT  = 1,
  parameter int MD_TIMEOUT = 40,
  parameter int EXC_REG    = 26
) (
  input  logic           clk,
  input  logic           reset,
  wb_sequencer_if.slave  bus
);

  localparam int MAX_ML  = (MEM_LAT > SHIFT_LAT) ? MEM_LAT : SHIFT_LAT;
  localparam int CNT_MAX = (MD_TIMEOUT > MAX_ML) ? MD_TIMEOUT : MAX_ML;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              md_wait_q, md_wait_d;
  logic [2:0]        wd_sel_q, wd_sel_d;
  logic [4:0]        wr_reg_q, wr_reg_d;
  logic              err_q, err_d;
  logic              to_done_q, to_done_d;

  logic              dec_legal;
  logic [2:0]        dec_sel;
  logic [4:0]        dec_dest;
  logic [CNT_W-1:0]  dec_wait;
  logic              dec_md;

  // Kind decode; for mult/div kinds dec_wait holds the timeout budget.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dec_legal = 1'b1;
    dec_sel   = 3'b001;
    dec_dest  = bus.rd;
    dec_wait  = '0;
    dec_md    = 1'b0;
    case (bus.wb_kind)
      4'd0: dec_dest = bus.rd;
      4'd1: dec_dest = bus.rt;
      4'd2: begin dec_sel = 3'b011; dec_dest = bus.rt; dec_wait = CNT_W'(MEM_LAT); end
      4'd3: begin dec_sel = 3'b100; dec_md = 1'b1; dec_wait = CNT_W'(MD_TIMEOUT); end
      4'd4: begin dec_sel = 3'b101; dec_md = 1'b1; dec_wait = CNT_W'(MD_TIMEOUT); end
      4'd5: begin dec_sel = 3'b110; dec_wait = CNT_W'(SHIFT_LAT); end
      4'd6: begin dec_sel = 3'b111; dec_dest = 5'd31; end
      4'd7: begin dec_sel = 3'b000; dec_dest = 5'(EXC_REG); end
      4'd8: begin dec_sel = 3'b010; dec_dest = bus.rt; dec_wait = CNT_W'(MEM_LAT - 1); end
      default: dec_legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      md_wait_q <= 1'b0;
      wd_sel_q  <= 3'b001;
      wr_reg_q  <= 5'd0;
      err_q     <= 1'b0;
      to_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_wait_q <= md_wait_d;
      wd_sel_q  <= wd_sel_d;
      wr_reg_q  <= wr_reg_d;
      err_q     <= err_d;
      to_done_q <= to_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_wait_d = md_wait_q;
    wd_sel_d  = wd_sel_q;
    wr_reg_d  = wr_reg_q;
    err_d     = err_q;
    to_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.wb_req) begin
          if (!dec_legal) begin
            err_d = 1'b1;
          end else begin
            wd_sel_d  = dec_sel;
            wr_reg_d  = dec_dest;
            md_wait_d = dec_md;
            cnt_d     = dec_wait;
            if (dec_md ? !bus.md_busy : (dec_wait == '0)) state_d = S_WRITE;
            else                                          state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.wb_req) err_d = 1'b1;
        if (md_wait_q) begin
          if (!bus.md_busy) begin
            state_d = S_WRITE;
          end else if (cnt_q <= CNT_ONE) begin
            // Timed out: report completion with an error but never write.
            state_d   = S_IDLE;
            err_d     = 1'b1;
            to_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else if (cnt_q <= CNT_ONE) begin
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WRITE: begin
        if (bus.wb_req) err_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Writes to register 0 complete normally but never strobe the bank.
  always_comb begin
    bus.wd_sel    = wd_sel_q;
    bus.wr_reg    = wr_reg_q;
    bus.reg_write = (state_q == S_WRITE) && (wr_reg_q != 5'd0);
    bus.busy      = (state_q != S_IDLE);
    bus.wb_done   = (state_q == S_WRITE) || to_done_q;
    bus.wb_err    = err_q;
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: reset state, a table of per-kind
// vectors, hand-written multi-cycle sequences and a randomized transaction run.
module tb_wb_sequencer;

  localparam int MEM_LAT    = 2;
  localparam int SHIFT_LAT  = 1;
  localparam int MD_TIMEOUT = 40;
  localparam int EXC_REG    = 26;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  wb_sequencer_if bus ();

  wb_sequencer #(
    .MEM_LAT   (MEM_LAT),
    .SHIFT_LAT (SHIFT_LAT),
    .MD_TIMEOUT(MD_TIMEOUT),
    .EXC_REG   (EXC_REG)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] kind;
    logic [4:0] rd;
    logic [4:0] rt;
    int         nbusy;
    logic [2:0] sel;
    logic [4:0] dest;
    int         lat;
    int         writes;
    bit         err;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.wb_req  = 1'b0;
    bus.wb_kind = 4'd0;
    bus.rd      = 5'd0;
    bus.rt      = 5'd0;
    bus.md_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Issue one request in the current cycle and observe a bounded window.
  // md_busy is high for the first nbusy cycles counting the acceptance cycle.
  task automatic run_txn(input logic [3:0] kind, input logic [4:0] rd, input logic [4:0] rt,
                         input int nbusy, input int extra_c,
                         output int o_lat, output int o_done, output int o_write, output int o_busy,
                         output logic [2:0] o_sel, output logic [4:0] o_reg, output bit o_hold);
    int bound;
    bound   = MD_TIMEOUT + 8;
    o_lat   = 0;
    o_done  = 0;
    o_write = 0;
    o_busy  = 0;
    o_hold  = 1'b1;
    o_sel   = 3'b0;
    o_reg   = 5'b0;
    bus.wb_req  = 1'b1;
    bus.wb_kind = kind;
    bus.rd      = rd;
    bus.rt      = rt;
    bus.md_busy = (nbusy > 0);
    for (int c = 1; c <= bound; c++) begin
      @(posedge clk);
      #1;
      bus.wb_req  = (c == extra_c);
      bus.md_busy = (c < nbusy);
      if (c == 1) begin
        o_sel = bus.wd_sel;
        o_reg = bus.wr_reg;
      end else if (bus.wd_sel !== o_sel || bus.wr_reg !== o_reg) begin
        o_hold = 1'b0;
      end
      if (bus.busy)      o_busy++;
      if (bus.reg_write) o_write++;
      if (bus.wb_done) begin
        o_done++;
        if (o_lat == 0) o_lat = c;
      end
      if (o_lat != 0 && c >= o_lat + 2) break;
    end
    bus.wb_req  = 1'b0;
    bus.md_busy = 1'b0;
  endtask

  // Reference: what the kind table says, in terms of wait cycles and latency.
  function automatic void model(input logic [3:0] kind, input logic [4:0] rd, input logic [4:0] rt,
                                input int nbusy, output bit legal, output logic [2:0] sel,
                                output logic [4:0] dest, output int lat, output bit timeout);
    int wait_cyc;
    legal    = 1'b1;
    timeout  = 1'b0;
    wait_cyc = 0;
    sel      = 3'b001;
    dest     = rd;
    case (kind)
      4'd0: begin sel = 3'b001; dest = rd; end
      4'd1: begin sel = 3'b001; dest = rt; end
      4'd2: begin sel = 3'b011; dest = rt; wait_cyc = MEM_LAT; end
      4'd3, 4'd4: begin
        sel  = (kind == 4'd3) ? 3'b100 : 3'b101;
        dest = rd;
        if (nbusy > MD_TIMEOUT) timeout = 1'b1;
        else                    wait_cyc = nbusy;
      end
      4'd5: begin sel = 3'b110; dest = rd; wait_cyc = SHIFT_LAT; end
      4'd6: begin sel = 3'b111; dest = 5'd31; end
      4'd7: begin sel = 3'b000; dest = 5'(EXC_REG); end
      4'd8: begin sel = 3'b010; dest = rt; wait_cyc = MEM_LAT - 1; end
      default: legal = 1'b0;
    endcase
    lat = !legal ? 0 : (timeout ? MD_TIMEOUT + 1 : wait_cyc + 1);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int o_lat, o_done, o_write, o_busy;
    logic [2:0] o_sel;
    logic [4:0] o_reg;
    bit o_hold;
    int seen;

    vecs[0]  = '{4'd0,  5'd5, 5'd7,  0, 3'b001, 5'd5,  1, 1, 1'b0};
    vecs[1]  = '{4'd1,  5'd3, 5'd12, 0, 3'b001, 5'd12, 1, 1, 1'b0};
    vecs[2]  = '{4'd2,  5'd1, 5'd9,  0, 3'b011, 5'd9,  3, 1, 1'b0};
    vecs[3]  = '{4'd3,  5'd4, 5'd2,  0, 3'b100, 5'd4,  1, 1, 1'b0};
    vecs[4]  = '{4'd4,  5'd6, 5'd2,  6, 3'b101, 5'd6,  7, 1, 1'b0};
    vecs[5]  = '{4'd5,  5'd8, 5'd2,  0, 3'b110, 5'd8,  2, 1, 1'b0};
    vecs[6]  = '{4'd6,  5'd3, 5'd4,  0, 3'b111, 5'd31, 1, 1, 1'b0};
    vecs[7]  = '{4'd7,  5'd3, 5'd4,  0, 3'b000, 5'd26, 1, 1, 1'b0};
    vecs[8]  = '{4'd8,  5'd3, 5'd10, 0, 3'b010, 5'd10, 2, 1, 1'b0};
    vecs[9]  = '{4'd1,  5'd3, 5'd0,  0, 3'b001, 5'd0,  1, 0, 1'b0};
    vecs[10] = '{4'd3,  5'd0, 5'd9,  2, 3'b100, 5'd0,  3, 0, 1'b0};
    vecs[11] = '{4'd12, 5'd9, 5'd9,  0, 3'b100, 5'd0,  0, 0, 1'b1};

    do_reset();
    check("rst_wd_sel",    32'(bus.wd_sel),    32'd1);
    check("rst_wr_reg",    32'(bus.wr_reg),    32'd0);
    check("rst_reg_write", 32'(bus.reg_write), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_wb_done",   32'(bus.wb_done),   32'd0);
    check("rst_wb_err",    32'(bus.wb_err),    32'd0);

    // Table-driven vectors, one per kind plus destination-0 and illegal cases.
    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].kind, vecs[i].rd, vecs[i].rt, vecs[i].nbusy, 0,
              o_lat, o_done, o_write, o_busy, o_sel, o_reg, o_hold);
      check($sformatf("vec%0d_lat", i),    32'(o_lat),   32'(vecs[i].lat));
      check($sformatf("vec%0d_done", i),   32'(o_done),  (vecs[i].lat != 0) ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_write", i),  32'(o_write), 32'(vecs[i].writes));
      check($sformatf("vec%0d_sel", i),    32'(o_sel),   32'(vecs[i].sel));
      check($sformatf("vec%0d_reg", i),    32'(o_reg),   32'(vecs[i].dest));
      check($sformatf("vec%0d_busy", i),   32'(o_busy),  32'(vecs[i].lat));
      check($sformatf("vec%0d_hold", i),   32'(o_hold),  32'd1);
      check($sformatf("vec%0d_err", i),    32'(bus.wb_err), 32'(vecs[i].err));
    end

    // Mult/div timeout: busy stuck high, done pulses without a write.
    do_reset();
    run_txn(4'd4, 5'd7, 5'd0, 60, 0, o_lat, o_done, o_write, o_busy, o_sel, o_reg, o_hold);
    check("to_lat",   32'(o_lat),      32'(MD_TIMEOUT + 1));
    check("to_write", 32'(o_write),    32'd0);
    check("to_busy",  32'(o_busy),     32'(MD_TIMEOUT));
    check("to_err",   32'(bus.wb_err), 32'd1);

    // JAL, request during its WRITE cycle (ignored), then EXC accepted in the next IDLE cycle.
    do_reset();
    bus.wb_req = 1'b1; bus.wb_kind = 4'd6; bus.rd = 5'd2; bus.rt = 5'd3;
    @(posedge clk); #1;
    check("jal_reg_write", 32'(bus.reg_write), 32'd1);
    check("jal_wr_reg",    32'(bus.wr_reg),    32'd31);
    check("jal_wd_sel",    32'(bus.wd_sel),    32'd7);
    check("jal_done",      32'(bus.wb_done),   32'd1);
    bus.wb_kind = 4'd7;
    @(posedge clk); #1;
    check("gap_busy",      32'(bus.busy),      32'd0);
    check("gap_reg_write", 32'(bus.reg_write), 32'd0);
    check("gap_wr_reg",    32'(bus.wr_reg),    32'd31);
    @(posedge clk); #1;
    bus.wb_req = 1'b0;
    check("exc_reg_write", 32'(bus.reg_write), 32'd1);
    check("exc_wr_reg",    32'(bus.wr_reg),    32'd26);
    check("exc_wd_sel",    32'(bus.wd_sel),    32'd0);
    check("exc_err",       32'(bus.wb_err),    32'd1);
    @(posedge clk); #1;
    check("exc_after_busy", 32'(bus.busy),     32'd0);

    // Reset during the first WAIT cycle of a LOAD aborts it with no pulses.
    do_reset();
    bus.wb_req = 1'b1; bus.wb_kind = 4'd2; bus.rt = 5'd9;
    @(posedge clk); #1;
    bus.wb_req = 1'b0;
    check("mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_wd_sel",    32'(bus.wd_sel),    32'd1);
    check("abort_wr_reg",    32'(bus.wr_reg),    32'd0);
    check("abort_busy",      32'(bus.busy),      32'd0);
    check("abort_reg_write", 32'(bus.reg_write), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.reg_write || bus.wb_done || bus.busy) seen++;
    end
    check("abort_no_pulse", 32'(seen), 32'd0);

    // Randomized transactions against the reference model, with periodic resets.
    begin
      bit exp_err;
      logic [2:0] last_sel;
      logic [4:0] last_reg;
      for (int n = 0; n < 150; n++) begin
        logic [3:0] kind;
        logic [4:0] rd, rt;
        int nbusy, extra_c, lat, bcyc;
        bit legal, to;
        logic [2:0] esel;
        logic [4:0] edest;
        if (n % 25 == 0) begin
          do_reset();
          exp_err  = 1'b0;
          last_sel = 3'b001;
          last_reg = 5'd0;
        end
        kind  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
        rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        rt    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        nbusy = ($urandom_range(0, 9) == 0) ? int'($urandom_range(38, 45)) : int'($urandom_range(0, 8));
        model(kind, rd, rt, nbusy, legal, esel, edest, lat, to);
        bcyc    = !legal ? 0 : (to ? MD_TIMEOUT : lat);
        extra_c = (bcyc > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, bcyc)) : 0;
        if (!legal) begin
          esel  = last_sel;
          edest = last_reg;
        end
        exp_err = exp_err | !legal | to | (extra_c != 0);
        run_txn(kind, rd, rt, nbusy, extra_c, o_lat, o_done, o_write, o_busy, o_sel, o_reg, o_hold);
        check($sformatf("rnd%0d_k%0d_lat", n, kind),   32'(o_lat),   32'(lat));
        check($sformatf("rnd%0d_k%0d_done", n, kind),  32'(o_done),  legal ? 32'd1 : 32'd0);
        check($sformatf("rnd%0d_k%0d_write", n, kind), 32'(o_write),
              (legal && !to && edest != 5'd0) ? 32'd1 : 32'd0);
        check($sformatf("rnd%0d_k%0d_sel", n, kind),   32'(o_sel),   32'(esel));
        check($sformatf("rnd%0d_k%0d_reg", n, kind),   32'(o_reg),   32'(edest));
        check($sformatf("rnd%0d_k%0d_busy", n, kind),  32'(o_busy),  32'(bcyc));
        check($sformatf("rnd%0d_k%0d_hold", n, kind),  32'(o_hold),  32'd1);
        check($sformatf("rnd%0d_k%0d_err", n, kind),   32'(bus.wb_err), 32'(exp_err));
        last_sel = esel;
        last_reg = edest;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
- Multicycle write-back controller for the register-file write-data path.
- Accepts one write-back request per instruction from the main control FSM and waits the required latency or handshake for the data source.
- Then drives the 3-bit write-data selector, destination register number and a single-cycle register write strobe.
- Sits between the control unit and the write-data mux / register bank.

Parameters:
- MEM_LAT, 2, cycles from load request until MDR holds valid data.
- SHIFT_LAT, 1, cycles from shift request until shifter output is valid.
- MD_TIMEOUT, 40, max cycles waiting for md_busy to drop before error.
- EXC_REG, 26, destination register for the exception constant write.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb_req  in  1  request strobe, sampled only in IDLE.
- wb_kind  in  4  write-back kind, encoding below.
- rd  in  5  R-type destination field.
- rt  in  5  I-type destination field.
- md_busy  in  1  mult/div unit busy; HI/LO invalid while high.
- wd_sel  out  3  write-data mux selector.
- wr_reg  out  5  register bank write address.
- reg_write  out  1  register bank write enable, one-cycle pulse.
- busy  out  1  request in progress.
- wb_done  out  1  one-cycle completion pulse.
- wb_err  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous and active-high.
- Reset values: state IDLE, wd_sel=3'b001, wr_reg=0, reg_write=0, busy=0, wb_done=0, wb_err=0, counter=0.
- Kind table (kind: selector, destination, wait):
  - 0 ALU_R: 001, rd, none.
  - 1 ALU_I: 001, rt, none.
  - 2 LOAD: 011, rt, MEM_LAT cycles.
  - 3 MFHI: 100, rd, md_busy low.
  - 4 MFLO: 101, rd, md_busy low.
  - 5 SHIFT: 110, rd, SHIFT_LAT cycles.
  - 6 JAL: 111, 31, none.
  - 7 EXC: 000 (constant 227), EXC_REG, none.
  - 8 MEMDIR: 010, rt, MEM_LAT-1 cycles.
  - 9-15 illegal.
- States:
  - IDLE: on wb_req, latch kind, selector and destination.
    - Illegal kind: set wb_err, stay IDLE, no write.
    - Zero wait: go to WRITE.
    - Otherwise: go to WAIT, load counter.
  - WAIT, fixed-latency kinds: counter decrements each cycle; go to WRITE when it reaches 1.
  - WAIT, MFHI/MFLO: go to WRITE in the first cycle md_busy=0.
    - If md_busy=0 at acceptance, go to WRITE directly.
    - If MD_TIMEOUT cycles elapse in WAIT: set wb_err, pulse wb_done, return to IDLE without writing.
  - WRITE: reg_write=1 and wb_done=1 for exactly one cycle, then IDLE.
- Latency from acceptance edge to reg_write:
  - Zero-wait kinds: 1 cycle.
  - LOAD: MEM_LAT+1 cycles.
  - SHIFT: SHIFT_LAT+1 cycles.
- Output timing:
  - wd_sel and wr_reg are registered at acceptance and held stable from the cycle after acceptance through the WRITE cycle.
  - wd_sel and wr_reg keep their last values in IDLE.
- busy=1 in WAIT and WRITE; 0 in IDLE.
- wb_req while busy: request ignored, wb_err set, current operation unaffected.
- wb_req arriving in the WRITE cycle is ignored. A new request is accepted in the first IDLE cycle, so back-to-back zero-wait requests complete every 2 cycles.
- Destination 0: sequence runs normally and wb_done pulses, but reg_write stays 0. Exception: EXC with EXC_REG=0 behaves the same way.
- Zero-latency parameter: MEMDIR with MEM_LAT=1 is treated as zero wait.
- Reset mid-operation: immediate return to IDLE; no reg_write or wb_done pulse is ever produced for the aborted request.

Test Plan:
- Reset, then ALU_R with rd=5 → next cycle reg_write=1, wr_reg=5, wd_sel=001, wb_done=1; busy drops the cycle after.
- LOAD with rt=9, MEM_LAT=2 → reg_write asserted exactly 3 cycles after acceptance, wd_sel=011, wr_reg=9.
- MFLO with md_busy held high 6 cycles → reg_write occurs the cycle after md_busy falls, wd_sel=101.
  - Repeat with md_busy stuck high → wb_err=1 after 40 cycles, no reg_write.
- JAL then immediate EXC → wr_reg=31 sel=111, then wr_reg=26 sel=000; wb_req pulsed during JAL WRITE is ignored.
- ALU_I with rt=0 → wb_done pulses, reg_write stays 0. wb_kind=12 → wb_err=1, busy stays 0.
- Assert reset mid-LOAD (cycle 1 of WAIT) → outputs return to reset values immediately; no write follows reset release.
